// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Multi-cycle sequencer for the 16-bit stack/ALU/branch datapath. It fetches
// through a req/ack instruction port, decodes the IR and then drives the PC,
// IR, SP, register-bank, flag and data-memory strobes over several cycles per
// instruction. Both memory ports may insert any number of wait cycles. A
// retired-instruction counter is kept. An illegal opcode parks the FSM in
// HALT until reset.
//
// State table:
//   state  | meaning
//   FETCH  | imemReq high; waiting for imemAck, then load IR and PC+1
//   DECODE | classify ir, no strobes
//   EXEC   | drive ALU function, load flags
//   WB     | hold ALU function, write ALU result to register bank
//   MEM    | dmemReq high until dmemAck; class-specific strobes on ack
//   BRANCH | conditional PC-relative load (pcLoad = cc)
//   HALT   | illegal opcode seen; everything idle until reset
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   ir                IR register contents (opcode in ir[15:8])
//   cc                branch condition, valid in BRANCH
//   imemAck/imemReq   instruction port handshake
//   dmemAck/dmemReq   data port handshake; dmemWe selects write
//   addrSel           data address source (SP, SP-1, ir[7:0])
//   pcLoad/pcSel      PC strobe and source (PC+1, PC+rel, memory)
//   irLoad            IR strobe
//   regLoad/wbSel     register-bank strobe and source (ALU, memory)
//   spLoad/spSel      SP strobe and direction (+1, -1)
//   flagLoad, aluOp   status flip-flop strobe and ALU function
//   halted, illegal   HALT indication and sticky illegal-opcode flag
//   state             current state, for debug
//   retired           completed-instruction count, wraps
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        ir,
    input  logic               cc,
    input  logic               imemAck,
    input  logic               dmemAck,
    output logic               imemReq,
    output logic               dmemReq,
    output logic               dmemWe,
    output logic [1:0]         addrSel,
    output logic               pcLoad,
    output logic [1:0]         pcSel,
    output logic               irLoad,
    output logic               regLoad,
    output logic               wbSel,
    output logic               spLoad,
    output logic               spSel,
    output logic               flagLoad,
    output logic [2:0]         aluOp,
    output logic               halted,
    output logic               illegal,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_MEM    = 3'd4,
        ST_BRANCH = 3'd5,
        ST_UNUSED = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP,
        CL_BRANCH,
        CL_STORE,
        CL_LOAD,
        CL_PUSH,
        CL_POP,
        CL_ALU,
        CL_RET,
        CL_ILLEGAL
    } iclass_t;

    localparam logic [1:0] ADDR_SP    = 2'b00;
    localparam logic [1:0] ADDR_SP_M1 = 2'b01;
    localparam logic [1:0] ADDR_IMM   = 2'b10;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_REL = 2'b01;
    localparam logic [1:0] PC_MEM = 2'b10;

    localparam logic [2:0] ALU_PASS = 3'b110;

    state_t               state_q, state_d;
    logic [COUNT_W-1:0]   retired_q, retired_d;
    logic                 illegal_q, illegal_d;
    iclass_t              iclass;

    // The low byte of ir feeds the datapath (address/offset), not the FSM.
    logic unused_ir_low;
    assign unused_ir_low = ^ir[7:0];

    // ------------------------------------------------------------------
    // Instruction class. ir is the IR register, so it stays valid from
    // DECODE through the end of the instruction and MEM/EXEC reuse it.
    // ------------------------------------------------------------------
    always_comb begin
        iclass = CL_ILLEGAL;
        case (ir[15:12])
            4'h0: iclass = CL_NOP;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
            4'h6, 4'h7, 4'h8, 4'h9: iclass = CL_BRANCH;
            4'hA: iclass = ir[11] ? CL_LOAD : CL_STORE;
            4'hF: begin
                case (ir[11:10])
                    2'b00:   iclass = CL_PUSH;
                    2'b01:   iclass = CL_POP;
                    2'b10:   iclass = CL_ALU;
                    default: iclass = CL_RET;
                endcase
            end
            default: iclass = CL_ILLEGAL;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state. Acks only matter in the state that raised the matching
    // request, so a stray ack elsewhere cannot move the FSM.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_FETCH: begin
                if (imemAck) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (iclass)
                    CL_NOP:    state_d = ST_FETCH;
                    CL_BRANCH: state_d = ST_BRANCH;
                    CL_ALU:    state_d = ST_EXEC;
                    CL_PUSH, CL_POP, CL_RET,
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    default: begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_MEM: begin
                if (dmemAck) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase

        // Every arrival in FETCH from elsewhere closes one instruction.
        // Illegal opcodes go to HALT instead and are never counted.
        if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) begin
            retired_d = retired_q + COUNT_W'(1);
        end else begin
            retired_d = retired_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        imemReq  = 1'b0;
        dmemReq  = 1'b0;
        dmemWe   = 1'b0;
        addrSel  = ADDR_SP;
        pcLoad   = 1'b0;
        pcSel    = PC_INC;
        irLoad   = 1'b0;
        regLoad  = 1'b0;
        wbSel    = 1'b0;
        spLoad   = 1'b0;
        spSel    = 1'b0;
        flagLoad = 1'b0;
        aluOp    = ALU_PASS;

        case (state_q)
            ST_FETCH: begin
                imemReq = 1'b1;
                if (imemAck) begin
                    irLoad = 1'b1;
                    pcLoad = 1'b1;
                    pcSel  = PC_INC;
                end
            end
            ST_BRANCH: begin
                pcLoad = cc;
                pcSel  = PC_REL;
            end
            ST_EXEC: begin
                aluOp    = {1'b0, ir[9:8]};
                flagLoad = 1'b1;
            end
            ST_WB: begin
                aluOp   = {1'b0, ir[9:8]};
                regLoad = 1'b1;
                wbSel   = 1'b0;
            end
            ST_MEM: begin
                // Direction and address are held for the whole access so the
                // memory sees a stable request; strobes fire on the ack only.
                dmemReq = 1'b1;
                case (iclass)
                    CL_PUSH: begin
                        dmemWe  = 1'b1;
                        addrSel = ADDR_SP_M1;
                        if (dmemAck) begin
                            spLoad = 1'b1;
                            spSel  = 1'b1;
                        end
                    end
                    CL_POP: begin
                        addrSel = ADDR_SP;
                        if (dmemAck) begin
                            regLoad = 1'b1;
                            wbSel   = 1'b1;
                            spLoad  = 1'b1;
                            spSel   = 1'b0;
                        end
                    end
                    CL_RET: begin
                        addrSel = ADDR_SP;
                        if (dmemAck) begin
                            pcLoad = 1'b1;
                            pcSel  = PC_MEM;
                            spLoad = 1'b1;
                            spSel  = 1'b0;
                        end
                    end
                    CL_LOAD: begin
                        addrSel = ADDR_IMM;
                        if (dmemAck) begin
                            regLoad = 1'b1;
                            wbSel   = 1'b1;
                        end
                    end
                    CL_STORE: begin
                        addrSel = ADDR_IMM;
                        dmemWe  = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase

        // Reset wins over everything in the same cycle: a pending memory
        // access is abandoned without updating PC, SP or the register bank.
        if (reset) begin
            imemReq  = 1'b0;
            dmemReq  = 1'b0;
            pcLoad   = 1'b0;
            irLoad   = 1'b0;
            regLoad  = 1'b0;
            spLoad   = 1'b0;
            flagLoad = 1'b0;
        end
    end

    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic [15:0]   ir;
    logic          cc;
    logic          imemAck;
    logic          dmemAck;
    logic          imemReq;
    logic          dmemReq;
    logic          dmemWe;
    logic [1:0]    addrSel;
    logic          pcLoad;
    logic [1:0]    pcSel;
    logic          irLoad;
    logic          regLoad;
    logic          wbSel;
    logic          spLoad;
    logic          spSel;
    logic          flagLoad;
    logic [2:0]    aluOp;
    logic          halted;
    logic          illegal;
    logic [2:0]    state;
    logic [CW-1:0] retired;

    multicycle_controller #(.COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .ir(ir), .cc(cc),
        .imemAck(imemAck), .dmemAck(dmemAck),
        .imemReq(imemReq), .dmemReq(dmemReq), .dmemWe(dmemWe),
        .addrSel(addrSel), .pcLoad(pcLoad), .pcSel(pcSel),
        .irLoad(irLoad), .regLoad(regLoad), .wbSel(wbSel),
        .spLoad(spLoad), .spSel(spSel), .flagLoad(flagLoad),
        .aluOp(aluOp), .halted(halted), .illegal(illegal),
        .state(state), .retired(retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    logic [CW-1:0] model_ret = '0;

    // Per-instruction summary of everything the controller did.
    typedef struct packed {
        logic [7:0] cycles;
        logic [3:0] ireq_n;
        logic [1:0] pc_n;
        logic [1:0] pc_sel;
        logic [1:0] sp_n;
        logic       sp_sel;
        logic [1:0] reg_n;
        logic       wb;
        logic [1:0] flag_n;
        logic [2:0] alu;
        logic [2:0] alu_wb;
        logic [1:0] dwe_n;
        logic [1:0] addr;
        logic [3:0] dreq_n;
        logic       stable;
        logic [1:0] noack_n;
        logic       halted;
    } sig_t;

    typedef struct {
        logic [15:0] ir;
        logic        c;
        int          iw;
        int          dw;
        sig_t        exp;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic sig_t mk(int cyc, int irq, int pcn, int pcs, int spn, int sps,
                                int rgn, int wb, int fln, int alu, int dwn, int adr, int drq);
        sig_t s;
        s         = '0;
        s.cycles  = 8'(cyc);
        s.ireq_n  = 4'(irq);
        s.pc_n    = 2'(pcn);
        s.pc_sel  = 2'(pcs);
        s.sp_n    = 2'(spn);
        s.sp_sel  = 1'(sps);
        s.reg_n   = 2'(rgn);
        s.wb      = 1'(wb);
        s.flag_n  = 2'(fln);
        s.alu     = 3'(alu);
        s.alu_wb  = 3'(alu);
        s.dwe_n   = 2'(dwn);
        s.addr    = 2'(adr);
        s.dreq_n  = 4'(drq);
        s.stable  = 1'b1;
        return s;
    endfunction

    // Reference model: totals per instruction from the class rules and
    // the memory wait counts, no cycle-level state.
    function automatic sig_t model_sig(logic [15:0] instr, logic c, int iw, int dw);
        sig_t s;
        int   cyc;
        s        = '0;
        s.stable = 1'b1;
        cyc      = 1 + iw;
        s.ireq_n = 4'(1 + iw);
        s.pc_n   = 2'd1;
        if (instr[15:12] == 4'h0) begin
            cyc = cyc + 1;
        end else if (instr[15:12] <= 4'h9) begin
            cyc = cyc + 2;
            if (c) begin
                s.pc_n   = 2'd2;
                s.pc_sel = 2'd1;
            end
        end else if (instr[15:12] == 4'hA) begin
            cyc      = cyc + 2 + dw;
            s.dreq_n = 4'(1 + dw);
            s.addr   = 2'd2;
            if (instr[11]) begin
                s.reg_n = 2'd1;
                s.wb    = 1'b1;
            end else begin
                s.dwe_n = 2'd1;
            end
        end else if (instr[15:12] == 4'hF) begin
            if (instr[11:10] == 2'b10) begin
                cyc      = cyc + 3;
                s.flag_n = 2'd1;
                s.alu    = {1'b0, instr[9:8]};
                s.alu_wb = {1'b0, instr[9:8]};
                s.reg_n  = 2'd1;
            end else begin
                cyc      = cyc + 2 + dw;
                s.dreq_n = 4'(1 + dw);
                s.sp_n   = 2'd1;
                if (instr[11:10] == 2'b00) begin
                    s.sp_sel = 1'b1;
                    s.dwe_n  = 2'd1;
                    s.addr   = 2'd1;
                end else if (instr[11:10] == 2'b01) begin
                    s.reg_n = 2'd1;
                    s.wb    = 1'b1;
                end else begin
                    s.pc_n   = 2'd2;
                    s.pc_sel = 2'd2;
                end
            end
        end else begin
            cyc      = cyc + 1;
            s.halted = 1'b1;
        end
        s.cycles = 8'(cyc);
        return s;
    endfunction

    // Runs one instruction from the start of its FETCH cycle (posedge+1)
    // acting as both memories; returns at posedge+1 of the next FETCH or
    // on reaching HALT.
    task automatic do_instr(input logic [15:0] instr, input logic c, input int iw,
                            input int dw, input bit noise, output sig_t o, output bit done);
        int   iseen;
        int   dseen;
        bit   fetched;
        bit   dfirst;
        logic we0;
        logic [1:0] a0;
        iseen   = 0;
        dseen   = 0;
        fetched = 0;
        dfirst  = 0;
        we0     = 1'b0;
        a0      = 2'b00;
        done    = 0;
        o        = '0;
        o.stable = 1'b1;
        for (int k = 0; k < 64; k++) begin
            imemAck = 1'b0;
            dmemAck = 1'b0;
            cc      = c;
            #1;
            if (imemReq) begin
                if (iseen == iw) imemAck = 1'b1;
                else iseen++;
            end else if (noise) begin
                imemAck = 1'($urandom_range(0, 1));
            end
            if (dmemReq) begin
                if (dseen == dw) dmemAck = 1'b1;
                else dseen++;
            end else if (noise) begin
                dmemAck = 1'($urandom_range(0, 1));
            end
            #1;
            o.cycles = o.cycles + 8'd1;
            if (imemReq) o.ireq_n = o.ireq_n + 4'd1;
            if (irLoad) fetched = 1;
            if (pcLoad) begin
                o.pc_n   = o.pc_n + 2'd1;
                o.pc_sel = pcSel;
            end
            if (spLoad) begin
                o.sp_n   = o.sp_n + 2'd1;
                o.sp_sel = spSel;
            end
            if (regLoad) begin
                o.reg_n = o.reg_n + 2'd1;
                o.wb    = wbSel;
                if (!wbSel) o.alu_wb = aluOp;
            end
            if (flagLoad) begin
                o.flag_n = o.flag_n + 2'd1;
                o.alu    = aluOp;
            end
            if (dmemReq && !dmemAck && (pcLoad || spLoad || regLoad))
                o.noack_n = o.noack_n + 2'd1;
            if (dmemReq) begin
                o.dreq_n = o.dreq_n + 4'd1;
                if (!dfirst) begin
                    dfirst = 1;
                    we0    = dmemWe;
                    a0     = addrSel;
                end else if (dmemWe !== we0 || addrSel !== a0) begin
                    o.stable = 1'b0;
                end
                if (dmemAck) begin
                    o.addr = addrSel;
                    if (dmemWe) o.dwe_n = o.dwe_n + 2'd1;
                end
            end
            @(posedge clk);
            #1;
            imemAck = 1'b0;
            dmemAck = 1'b0;
            if (fetched) ir = instr;
            if (fetched && (state == 3'd0 || state == 3'd7)) begin
                o.halted = (state == 3'd7);
                done     = 1;
                break;
            end
        end
    endtask

    task automatic run_check(input string nm, input logic [15:0] instr, input logic c,
                             input int iw, input int dw, input sig_t exp, input bit noise);
        sig_t o;
        bit   done;
        do_instr(instr, c, iw, dw, noise, o, done);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: state=%0d", nm, state);
        end
        checks++;
        if (o !== exp) begin
            errors++;
            $display("FAIL %s summary: got %h expected %h (ir=%h cc=%0d iw=%0d dw=%0d)",
                     nm, o, exp, instr, c, iw, dw);
        end
        if (!exp.halted) model_ret = model_ret + 1'b1;
        check({nm, " retired"}, 32'(retired), 32'(model_ret));
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        imemAck = 1'b1;
        dmemAck = 1'b1;
        ir      = 16'h0000;
        cc      = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        imemAck   = 1'b0;
        dmemAck   = 1'b0;
        model_ret = '0;
    endtask

    // Fetch instr, reach MEM, wait one cycle, then reset with an ack present.
    task automatic reset_in_mem(input string nm, input logic [15:0] instr);
        imemAck = 1'b0;
        dmemAck = 1'b0;
        #1;
        imemAck = 1'b1;
        #1;
        @(posedge clk);
        #1;
        imemAck = 1'b0;
        ir      = instr;
        @(posedge clk);
        #1;
        #1;
        check({nm, " in MEM"}, 32'(state), 32'd4);
        check({nm, " dmemReq"}, 32'(dmemReq), 32'd1);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        dmemAck = 1'b1;
        #1;
        check({nm, " spLoad@rst"}, 32'(spLoad), 32'd0);
        check({nm, " regLoad@rst"}, 32'(regLoad), 32'd0);
        check({nm, " pcLoad@rst"}, 32'(pcLoad), 32'd0);
        check({nm, " dmemReq@rst"}, 32'(dmemReq), 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        dmemAck = 1'b0;
        #1;
        check({nm, " state after"}, 32'(state), 32'd0);
        check({nm, " retired after"}, 32'(retired), 32'd0);
        model_ret = '0;
        @(posedge clk);
        #1;
    endtask

    vec_t       tbl[15];
    logic [2:0] seq[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        ir      = 16'h0000;
        cc      = 1'b0;
        imemAck = 1'b1;
        dmemAck = 1'b1;

        tbl[0]  = '{16'h0000, 1'b0, 0, 0, mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{16'h0000, 1'b1, 2, 0, mk(4, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{16'h2005, 1'b0, 0, 0, mk(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{16'h2005, 1'b1, 0, 0, mk(3, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{16'h1003, 1'b1, 1, 0, mk(4, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{16'hF900, 1'b0, 0, 0, mk(4, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0)};
        tbl[6]  = '{16'hFA00, 1'b1, 0, 0, mk(4, 1, 1, 0, 0, 0, 1, 0, 1, 2, 0, 0, 0)};
        tbl[7]  = '{16'hFB00, 1'b0, 1, 0, mk(5, 2, 1, 0, 0, 0, 1, 0, 1, 3, 0, 0, 0)};
        tbl[8]  = '{16'hF000, 1'b0, 0, 3, mk(6, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1, 1, 4)};
        tbl[9]  = '{16'hF400, 1'b0, 0, 1, mk(4, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 2)};
        tbl[10] = '{16'hA812, 1'b0, 0, 2, mk(5, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 2, 3)};
        tbl[11] = '{16'hA034, 1'b0, 0, 0, mk(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1)};
        tbl[12] = '{16'hF800, 1'b1, 0, 0, mk(4, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0)};
        tbl[13] = '{16'h9FFF, 1'b0, 0, 1, mk(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[14] = '{16'hFC00, 1'b0, 0, 0, mk(3, 1, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1)};

        // Reset with both acks high: strobes forced low, acks discarded.
        @(posedge clk);
        #1;
        #1;
        check("imemReq in reset", 32'(imemReq), 32'd0);
        check("irLoad in reset", 32'(irLoad), 32'd0);
        check("pcLoad in reset", 32'(pcLoad), 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        imemAck = 1'b0;
        dmemAck = 1'b0;
        #1;
        check("state after reset", 32'(state), 32'd0);
        check("retired after reset", 32'(retired), 32'd0);
        check("illegal after reset", 32'(illegal), 32'd0);
        check("halted after reset", 32'(halted), 32'd0);
        @(posedge clk);
        #1;

        // NOP stream, zero wait.
        for (int k = 0; k < 6; k++) begin
            imemAck = 1'b0;
            #1;
            if (imemReq) imemAck = 1'b1;
            #1;
            seq[k] = state;
            if (k == 0) check("imemReq cycle0", 32'(imemReq), 32'd1);
            @(posedge clk);
            #1;
        end
        imemAck = 1'b0;
        for (int k = 0; k < 6; k++)
            check($sformatf("nop state[%0d]", k), 32'(seq[k]), 32'(k % 2));
        check("retired after 3 nops", 32'(retired), 32'd3);
        model_ret = 4'd3;

        // Directed table.
        for (int i = 0; i < 15; i++)
            run_check($sformatf("vec%0d", i), tbl[i].ir, tbl[i].c, tbl[i].iw, tbl[i].dw,
                      tbl[i].exp, 1'b0);

        // Illegal opcode after RET: HALT, sticky flag, counter frozen.
        run_check("illegal B000", 16'hB000, 1'b0, 0, 0, model_sig(16'hB000, 1'b0, 0, 0), 1'b0);
        check("halted", 32'(halted), 32'd1);
        check("illegal flag", 32'(illegal), 32'd1);
        for (int k = 0; k < 3; k++) begin
            imemAck = 1'b1;
            dmemAck = 1'b1;
            #1;
            check("halt imemReq", 32'(imemReq), 32'd0);
            check("halt pcLoad", 32'(pcLoad), 32'd0);
            @(posedge clk);
            #1;
        end
        check("halt state held", 32'(state), 32'd7);
        check("halt retired held", 32'(retired), 32'(model_ret));
        do_reset();
        #1;
        check("state after halt reset", 32'(state), 32'd0);
        check("illegal after halt reset", 32'(illegal), 32'd0);
        check("halted after halt reset", 32'(halted), 32'd0);
        @(posedge clk);
        #1;

        // 16 NOPs wrap the 4-bit counter back to 0.
        for (int k = 0; k < 16; k++)
            run_check($sformatf("wrap%0d", k), 16'h0000, 1'b0, 0, 0,
                      model_sig(16'h0000, 1'b0, 0, 0), 1'b0);
        check("retired wrapped", 32'(retired), 32'd0);

        // Reset during MEM with simultaneous ack.
        run_check("pre-abort nop", 16'h0000, 1'b0, 0, 0, model_sig(16'h0000, 1'b0, 0, 0), 1'b0);
        reset_in_mem("abort push", 16'hF000);
        run_check("pre-abort nop2", 16'h0000, 1'b0, 0, 0, model_sig(16'h0000, 1'b0, 0, 0), 1'b0);
        reset_in_mem("abort pop", 16'hF400);

        // Random legal instructions with random waits and stray acks.
        for (int n = 0; n < 300; n++) begin
            logic [15:0] ins;
            logic        c;
            int          iw;
            int          dw;
            ins = 16'($urandom);
            while (ins[15:12] >= 4'hB && ins[15:12] <= 4'hE) ins = 16'($urandom);
            c  = 1'($urandom_range(0, 1));
            iw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            run_check($sformatf("rnd%0d", n), ins, c, iw, dw, model_sig(ins, c, iw, dw), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
